pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_pkg.sv | 29 ++
 rtl/pe_vld_pipe.sv | 53 +++++
 rtl/pe_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and widths for the PE sequencing controller.
// Holds the FSM encoding, config/counter widths and the delay-line payload.
package pe_seq_pkg;

   localparam int unsigned CFG_W     = 8;
   localparam int unsigned COL_CNT_W = 9;
   localparam int unsigned BIAS_W    = 5;
   localparam int unsigned LAT_DEF   = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      ROW    = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_e;

   typedef struct packed {
      logic             vld;
      logic [CFG_W-1:0] row;
      logic [CFG_W-1:0] col;
   } vld_pay_t;

   // Columns streamed per output row: two fill columns plus one per window.
   function automatic logic [COL_CNT_W-1:0] row_len(input logic [CFG_W-1:0] cols);
      return COL_CNT_W'(cols) + COL_CNT_W'(2);
   endfunction

endpackage

// File: rtl/pe_vld_pipe.sv
// Delay line that tracks which PE result cycles carry a valid window and its coordinates.
// Invalid slots carry an all-zero payload so idle coordinates read as 0.
module pe_vld_pipe
   import pe_seq_pkg::*;
#(
   parameter int unsigned DEPTH = LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_vld,
   input  logic [CFG_W-1:0] in_row,
   input  logic [CFG_W-1:0] in_col,
   output logic             out_vld,
   output logic [CFG_W-1:0] out_row,
   output logic [CFG_W-1:0] out_col
);

   vld_pay_t stage_q [DEPTH];
   vld_pay_t stage_d [DEPTH];

   // Shift one slot per cycle; flush empties every slot at once.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         stage_d[i] = '0;
      end
      if (!flush) begin
         if (in_vld) begin
            stage_d[0] = '{vld: 1'b1, row: in_row, col: in_col};
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign out_vld = stage_q[DEPTH-1].vld;
   assign out_row = stage_q[DEPTH-1].row;
   assign out_col = stage_q[DEPTH-1].col;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a 3x3 convolution PE: loads weights, streams image columns
// row by row and flags which PE result cycles hold a completed window.
module pe_seq_ctrl
   import pe_seq_pkg::*;
#(
   parameter int unsigned LAT = LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CFG_W-1:0]  cfg_cols,
   input  logic [CFG_W-1:0]  cfg_rows,
   input  logic [BIAS_W-1:0] cfg_exp_bias,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic              img_valid,
   output logic              img_ready,
   output logic              pe_en,
   output logic [BIAS_W-1:0] exp_bias,
   output logic              psum_valid,
   output logic [CFG_W-1:0]  out_row,
   output logic [CFG_W-1:0]  out_col,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned DRN_W = (LAT > 1) ? $clog2(LAT) : 1;

   state_e               state_q,     state_d;
   logic [CFG_W-1:0]     cols_q,      cols_d;
   logic [CFG_W-1:0]     rows_q,      rows_d;
   logic [CFG_W-1:0]     row_cnt_q,   row_cnt_d;
   logic [COL_CNT_W-1:0] col_cnt_q,   col_cnt_d;
   logic [DRN_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic [BIAS_W-1:0]    bias_q,      bias_d;
   logic                 w_ready_q,   w_ready_d;
   logic                 img_ready_q, img_ready_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 err_q,       err_d;

   logic                 row_last;
   logic                 job_last;
   logic                 drain_last;
   logic                 pipe_vld;
   logic                 flush;
   logic [CFG_W-1:0]     pipe_col;

   assign row_last   = (col_cnt_q == row_len(cols_q) - COL_CNT_W'(1));
   assign job_last   = (row_cnt_q == rows_q - CFG_W'(1));
   assign drain_last = (drain_cnt_q == DRN_W'(LAT - 1));
   assign pipe_col   = CFG_W'(col_cnt_q - COL_CNT_W'(2));

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cols_d      = cols_q;
      rows_d      = rows_q;
      bias_d      = bias_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      drain_cnt_d = drain_cnt_q;
      err_d       = err_q;
      flush       = 1'b0;
      pipe_vld    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               bias_d    = cfg_exp_bias;
               cols_d    = cfg_cols;
               rows_d    = cfg_rows;
               col_cnt_d = '0;
               row_cnt_d = '0;
               if ((cfg_cols != '0) && (cfg_rows != '0)) begin
                  state_d = LOAD_W;
                  err_d   = 1'b0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LOAD_W: begin
            if (w_valid) begin
               state_d = ROW;
            end
         end
         ROW: begin
            if (img_valid) begin
               // The first two columns of a row only prime the window.
               pipe_vld = (col_cnt_q >= COL_CNT_W'(2));
               if (row_last) begin
                  col_cnt_d = '0;
                  if (job_last) begin
                     row_cnt_d   = '0;
                     drain_cnt_d = '0;
                     state_d     = DRAIN;
                  end else begin
                     row_cnt_d = row_cnt_q + CFG_W'(1);
                  end
               end else begin
                  col_cnt_d = col_cnt_q + COL_CNT_W'(1);
               end
            end else if (col_cnt_q != '0) begin
               // A stall inside a row breaks the window; abort the job.
               err_d     = 1'b1;
               flush     = 1'b1;
               col_cnt_d = '0;
               row_cnt_d = '0;
               state_d   = IDLE;
            end
         end
         DRAIN: begin
            if (drain_last) begin
               state_d = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DRN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      w_ready_d   = (state_d == LOAD_W);
      img_ready_d = (state_d == ROW);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cols_q      <= '0;
         rows_q      <= '0;
         row_cnt_q   <= '0;
         col_cnt_q   <= '0;
         drain_cnt_q <= '0;
         bias_q      <= '0;
         w_ready_q   <= 1'b0;
         img_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cols_q      <= cols_d;
         rows_q      <= rows_d;
         row_cnt_q   <= row_cnt_d;
         col_cnt_q   <= col_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         bias_q      <= bias_d;
         w_ready_q   <= w_ready_d;
         img_ready_q <= img_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   pe_vld_pipe #(
      .DEPTH (LAT)
   ) u_vld_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_vld  (pipe_vld),
      .in_row  (row_cnt_q),
      .in_col  (pipe_col),
      .out_vld (psum_valid),
      .out_row (out_row),
      .out_col (out_col)
   );

   // The PE latches the weight in the handshake cycle itself.
   assign pe_en     = w_ready_q & w_valid;
   assign w_ready   = w_ready_q;
   assign img_ready = img_ready_q;
   assign exp_bias  = bias_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Randomized bench for pe_seq_ctrl: a job-level model predicts every output each
// cycle, and directed jobs pin the model with hand-computed numbers.
module tb_pe_seq_ctrl;

   localparam int unsigned LAT   = 2;
   localparam int          LAT_I = 2;
   localparam int P_IDLE = 0, P_LOADW = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] cfg_cols = '0;
   logic [7:0] cfg_rows = '0;
   logic [4:0] cfg_exp_bias = '0;
   logic       w_valid = 1'b0;
   logic       img_valid = 1'b0;
   logic       w_ready, img_ready, pe_en, psum_valid, busy, done, err;
   logic [4:0] exp_bias;
   logic [7:0] out_row, out_col;

   always #5 clk = ~clk;

   pe_seq_ctrl #(.LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_cols     (cfg_cols),
      .cfg_rows     (cfg_rows),
      .cfg_exp_bias (cfg_exp_bias),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .img_valid    (img_valid),
      .img_ready    (img_ready),
      .pe_en        (pe_en),
      .exp_bias     (exp_bias),
      .psum_valid   (psum_valid),
      .out_row      (out_row),
      .out_col      (out_col),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   typedef struct { int due; int row; int col; } pend_t;
   pend_t pend[$];

   int m_ph = P_IDLE, m_err = 0, m_bias = 0, m_cols = 0, m_rows = 0, m_acc = 0, m_done_at = 0;
   int cyc = 0;
   int checks = 0, errors = 0;
   int acc_cycs[$], ps_cycs[$], ps_rows[$], ps_cols[$], done_cycs[$];
   int pe_cnt = 0, wr_cnt = 0, busy_cnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = P_IDLE; m_err = 0; m_bias = 0; m_acc = 0;
      pend.delete();
   endtask

   always @(negedge rst) model_reset();

   // Job-level model: tracks total accepted columns and schedules results LAT cycles out.
   always @(posedge clk) begin
      int c, pos, r;
      pend_t e;
      c = cyc;
      cyc++;
      if (!rst) model_reset();
      else begin
         case (m_ph)
            P_IDLE: if (start) begin
               m_bias = int'(cfg_exp_bias);
               if (cfg_cols != 0 && cfg_rows != 0) begin
                  m_cols = int'(cfg_cols); m_rows = int'(cfg_rows);
                  m_acc = 0; m_err = 0; m_ph = P_LOADW;
               end else m_ph = P_DONE;
            end
            P_LOADW: if (w_valid) m_ph = P_STREAM;
            P_STREAM: begin
               if (img_valid) begin
                  pos = m_acc % (m_cols + 2);
                  r   = m_acc / (m_cols + 2);
                  if (pos >= 2) begin
                     e.due = c + LAT_I; e.row = r; e.col = pos - 2;
                     pend.push_back(e);
                  end
                  acc_cycs.push_back(c);
                  m_acc++;
                  if (m_acc == (m_cols + 2) * m_rows) begin
                     m_ph = P_DRAIN; m_done_at = c + LAT_I + 1;
                  end
               end else if (m_acc % (m_cols + 2) != 0) begin
                  m_err = 1; m_ph = P_IDLE;
                  while (pend.size() > 0 && pend[pend.size()-1].due > c) pend.pop_back();
               end
            end
            P_DRAIN: if (cyc == m_done_at) m_ph = P_DONE;
            default: m_ph = P_IDLE;
         endcase
      end
   end

   // Compare every output against the model in the middle of each cycle.
   always @(negedge clk) begin
      int ev, er, ec;
      ev = 0; er = 0; ec = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ev = 1; er = pend[0].row; ec = pend[0].col;
         void'(pend.pop_front());
      end
      chk("w_ready",    int'(w_ready),    int'(m_ph == P_LOADW));
      chk("img_ready",  int'(img_ready),  int'(m_ph == P_STREAM));
      chk("pe_en",      int'(pe_en),      int'(m_ph == P_LOADW && w_valid));
      chk("busy",       int'(busy),       int'(m_ph != P_IDLE));
      chk("done",       int'(done),       int'(m_ph == P_DONE));
      chk("err",        int'(err),        m_err);
      chk("exp_bias",   int'(exp_bias),   m_bias);
      chk("psum_valid", int'(psum_valid), ev);
      if (ev == 1 || !rst) begin
         chk("out_row", int'(out_row), er);
         chk("out_col", int'(out_col), ec);
      end
      if (psum_valid) begin
         ps_cycs.push_back(cyc); ps_rows.push_back(int'(out_row)); ps_cols.push_back(int'(out_col));
      end
      if (done)    done_cycs.push_back(cyc);
      if (pe_en)   pe_cnt++;
      if (w_ready) wr_cnt++;
      if (busy)    busy_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_cycs.delete(); ps_cycs.delete(); ps_rows.delete(); ps_cols.delete(); done_cycs.delete();
   endtask

   task automatic run_job(input int cols, input int rows, input int bias, input int wdly,
                          input int gap_pct, input int drop_at, input int row_gap,
                          input bit abort_drain);
      int n, wd, gcnt, pos;
      n = 0; wd = wdly; gcnt = 0;
      start = 1'b1; cfg_cols = 8'(cols); cfg_rows = 8'(rows); cfg_exp_bias = 5'(bias);
      tick();
      start = 1'b0;
      while (m_ph != P_IDLE && n < 2000) begin
         cfg_cols = 8'($urandom); cfg_rows = 8'($urandom); cfg_exp_bias = 5'($urandom);
         start = ($urandom_range(7) == 0);
         if (abort_drain && m_ph == P_DRAIN) begin
            start = 1'b0;
            rst = 1'b0;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_psum", int'(psum_valid), 0);
            chk("rst_bias", int'(exp_bias), 0);
            tick(); tick();
            rst = 1'b1;
            tick();
            continue;
         end
         w_valid = (m_ph == P_LOADW) ? (wd == 0) : 1'($urandom_range(1));
         if (m_ph == P_LOADW && wd > 0) wd--;
         if (m_ph == P_STREAM) begin
            pos = m_acc % (m_cols + 2);
            if (pos != 0) gcnt = 0;
            if (drop_at >= 0 && m_acc == drop_at && pos != 0) img_valid = 1'b0;
            else if (pos != 0) img_valid = 1'b1;
            else if (m_acc > 0 && gcnt < row_gap) begin img_valid = 1'b0; gcnt++; end
            else img_valid = (int'($urandom_range(99)) >= gap_pct);
         end else img_valid = 1'($urandom_range(1));
         tick();
         n++;
      end
      start = 1'b0; w_valid = 1'b0; img_valid = 1'b0;
      chk("job_timeout", int'(n >= 2000), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, d0, b0;
      #1 rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // 2 columns x 1 row, gapless.
      clear_logs();
      run_job(2, 1, 5, 0, 0, -1, 0, 1'b0);
      chk("s1_accepts", acc_cycs.size(), 4);
      chk("s1_psums", ps_cycs.size(), 2);
      if (ps_cycs.size() == 2 && acc_cycs.size() == 4) begin
         chk("s1_psum0_time", ps_cycs[0], acc_cycs[2] + 2);
         chk("s1_psum1_time", ps_cycs[1], acc_cycs[3] + 2);
         chk("s1_col0", ps_cols[0], 0);
         chk("s1_col1", ps_cols[1], 1);
      end
      chk("s1_dones", done_cycs.size(), 1);
      if (done_cycs.size() == 1 && acc_cycs.size() == 4)
         chk("s1_done_time", done_cycs[0], acc_cycs[3] + 3);
      tick();

      // 1 column x 3 rows with a 2-cycle gap between rows.
      clear_logs();
      run_job(1, 3, 9, 1, 0, -1, 2, 1'b0);
      chk("s2_psums", ps_cycs.size(), 3);
      for (int i = 0; i < ps_rows.size() && i < 3; i++) begin
         chk("s2_row", ps_rows[i], i);
         chk("s2_col", ps_cols[i], 0);
      end
      chk("s2_err", int'(err), 0);
      tick();

      // Weight arrives 5 cycles late.
      p0 = pe_cnt; b0 = wr_cnt;
      run_job(3, 1, 17, 5, 0, -1, 0, 1'b0);
      chk("s3_pe_pulses", pe_cnt - p0, 1);
      chk("s3_wready_cycles", wr_cnt - b0, 6);
      tick();

      // Stall after column 3 of row 0 of a 4-column job.
      clear_logs();
      run_job(4, 2, 3, 0, 0, 3, 0, 1'b0);
      chk("s4_err", int'(err), 1);
      chk("s4_busy", int'(busy), 0);
      repeat (4) tick();
      chk("s4_psums", ps_cycs.size(), 0);
      chk("s4_dones", done_cycs.size(), 0);

      // Zero rows.
      clear_logs();
      b0 = busy_cnt;
      run_job(3, 0, 21, 0, 0, -1, 0, 1'b0);
      chk("s5_dones", done_cycs.size(), 1);
      chk("s5_psums", ps_cycs.size(), 0);
      chk("s5_busy_cycles", busy_cnt - b0, 1);
      tick();

      // Reset while draining, then a fresh job.
      clear_logs();
      run_job(3, 2, 11, 0, 0, -1, 0, 1'b1);
      chk("s6_dones", done_cycs.size(), 0);
      clear_logs();
      run_job(2, 2, 6, 0, 0, -1, 0, 1'b0);
      chk("s6_psums", ps_cycs.size(), 4);
      chk("s6_dones_after", done_cycs.size(), 1);
      tick();

      // Widest row.
      clear_logs();
      run_job(255, 1, 30, 0, 0, -1, 0, 1'b0);
      chk("s7_psums", ps_cycs.size(), 255);
      if (ps_cols.size() == 255) chk("s7_last_col", ps_cols[254], 254);
      tick();

      for (int j = 0; j < 30; j++) begin
         int c, r, d;
         c = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(6, 1));
         r = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(4, 1));
         d = -1;
         if (c > 0 && r > 0 && $urandom_range(4) == 0)
            d = int'($urandom_range(r - 1)) * (c + 2) + int'($urandom_range(c + 1, 1));
         run_job(c, r, int'($urandom_range(31)), int'($urandom_range(3)), 30, d,
                 int'($urandom_range(2)), 1'b0);
         d0 = int'($urandom_range(3));
         for (int k = 0; k < d0; k++) begin
            w_valid = 1'($urandom_range(1)); img_valid = 1'($urandom_range(1));
            tick();
         end
         w_valid = 1'b0; img_valid = 1'b0;
      end

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
